// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time instruction-memory writer. It consumes a byte stream over a
// valid/ready handshake, assembles big-endian 32-bit words and writes them to
// consecutive word addresses. The processor is held in reset until a complete
// image with a matching XOR checksum has been received.
//
// Stream: CNT_HI, CNT_LO (word count N), N x 4 data bytes (MSB first), then
// one checksum byte equal to the XOR of all data bytes.
//
// Ports
//   clk        in   1    system clock, rising edge
//   reset      in   1    synchronous, active-high
//   in_valid   in   1    byte source has in_data available
//   in_data    in   8    stream byte
//   in_ready   out  1    byte accepted this cycle when in_valid is also high
//   imem_we    out  1    one-cycle write strobe per assembled word
//   imem_wa    out  AW   word address for imem_we
//   imem_wd    out  32   write data for imem_we
//   cpu_reset  out  1    processor reset, released after a verified image
//   done       out  1    image loaded with good checksum (sticky)
//   err        out  1    bad length or bad checksum (sticky)
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_wa,
  output logic [31:0]   imem_wd,
  output logic          cpu_reset,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_HDR_HI = 3'd0,
    S_HDR_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CHK    = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  // Largest image that fits the memory, in words.
  localparam logic [16:0] MAX_WORDS = 17'(1) << AW;

  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [AW:0]   ptr_q, ptr_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   asm_q, asm_d;
  logic [7:0]    sum_q, sum_d;
  logic          ready_q, ready_d;
  logic          we_q, we_d;
  logic [AW-1:0] wa_q, wa_d;
  logic [31:0]   wd_q, wd_d;
  logic          cpurst_q, cpurst_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          xfer;
  logic [15:0]   hdr_cnt;
  logic [16:0]   ptr_next;

  // States in which a byte can be taken from the source.
  function automatic logic accepts(input state_e s);
    return (s == S_HDR_HI) || (s == S_HDR_LO) || (s == S_DATA) || (s == S_CHK);
  endfunction

  // Word counts larger than the memory are rejected before any write.
  function automatic logic len_too_big(input logic [15:0] n);
    return {1'b0, n} > MAX_WORDS;
  endfunction

  assign xfer     = in_valid & ready_q;
  assign hdr_cnt  = {cnt_q[15:8], in_data};
  // Pointer is one bit wider than the address so N == 2**AW ends cleanly.
  assign ptr_next = 17'(ptr_q) + 17'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    asm_d    = asm_q;
    sum_d    = sum_q;
    we_d     = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    cpurst_d = cpurst_q;
    done_d   = done_q;
    err_d    = err_q;

    unique case (state_q)
      S_HDR_HI: begin
        if (xfer) begin
          cnt_d[15:8] = in_data;
          state_d     = S_HDR_LO;
        end
      end

      S_HDR_LO: begin
        if (xfer) begin
          cnt_d = hdr_cnt;
          if (hdr_cnt == 16'd0) begin
            state_d = S_CHK;
          end else if (len_too_big(hdr_cnt)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (xfer) begin
          asm_d = {asm_q[23:0], in_data};
          sum_d = sum_q ^ in_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            // Word complete: the write is registered, so it appears next cycle
            // without blocking the following byte.
            we_d  = 1'b1;
            wd_d  = {asm_q[23:0], in_data};
            wa_d  = ptr_q[AW-1:0];
            ptr_d = ptr_q + 1'b1;
            if (ptr_next == {1'b0, cnt_q}) begin
              state_d = S_CHK;
            end
          end
        end
      end

      S_CHK: begin
        if (xfer) begin
          if (in_data == sum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end

      S_DONE: begin
        // Release the processor one cycle after done rises.
        cpurst_d = 1'b0;
      end

      S_ERR: begin
        cpurst_d = 1'b1;
      end

      default: begin
        state_d = S_ERR;
        err_d   = 1'b1;
      end
    endcase

    ready_d = accepts(state_d);
  end

  always_ff @(posedge clk) begin
    // Assembly register needs no reset: byte_idx restarts at 0 and four
    // shifts overwrite it completely before it is ever written out.
    asm_q <= asm_d;
    cnt_q <= cnt_d;
    if (reset) begin
      state_q  <= S_HDR_HI;
      ptr_q    <= '0;
      idx_q    <= '0;
      sum_q    <= '0;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
      cpurst_q <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      ready_q  <= ready_d;
      we_q     <= we_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      cpurst_q <= cpurst_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign in_ready  = ready_q;
  assign imem_we   = we_q;
  assign imem_wa   = wa_q;
  assign imem_wd   = wd_q;
  assign cpu_reset = cpurst_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: a driver feeds byte streams, the expected memory
// writes are queued as each word-completing byte is handed over, and a monitor
// pops and compares every write strobe the loader produces.
module tb_imem_loader;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_wa;
  logic [31:0]   imem_wd;
  logic          cpu_reset;
  logic          done;
  logic          err;

  imem_loader #(.AW(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_wa(imem_wa),
    .imem_wd(imem_wd), .cpu_reset(cpu_reset), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          wa;
    logic [31:0] wd;
    int          t;
  } exp_t;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         done_age = 0;
  exp_t       expq[$];
  logic [7:0] stim[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (imem_we === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_we: got write wa=%0h wd=%0h expected no write", imem_wa, imem_wd);
      end else begin
        e = expq.pop_front();
        check("write_wa", 64'(imem_wa), 64'(e.wa));
        check("write_wd", 64'(imem_wd), 64'(e.wd));
        check("write_latency", 64'(cyc), 64'(e.t));
      end
    end
    if (done === 1'b1) begin
      done_age++;
      if (done_age == 1) check("cpurst_at_done", 64'(cpu_reset), 64'd1);
      if (done_age == 2) check("cpurst_release", 64'(cpu_reset), 64'd0);
    end else begin
      done_age = 0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_we", 64'(imem_we), 64'd0);
    check("rst_wa", 64'(imem_wa), 64'd0);
    check("rst_wd", 64'(imem_wd), 64'd0);
    check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    expq.delete();
    reset = 1'b0;
  endtask

  // Present one byte; returns at the falling edge just before the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit wend,
                           input int widx, input logic [31:0] wword);
    int guard;
    int n;
    exp_t e;
    guard = 0;
    if (gaps) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=%0b expected 1 within 50 cycles", in_ready);
    end else if (wend) begin
      e.wa = widx;
      e.wd = wword;
      e.t  = cyc + 1;
      expq.push_back(e);
    end
  endtask

  // Reference model: the outcome of a stream follows from its header and bytes.
  task automatic run_load(input bit gaps, input int abort_at);
    int          n;
    bit          ok_len;
    bit          exp_done;
    logic [7:0]  x;
    logic [31:0] w;
    bit          wend;
    n = int'({stim[0], stim[1]});
    ok_len = (n <= (1 << AW));
    x = 8'h00;
    exp_done = 1'b0;
    if (ok_len) begin
      for (int i = 2; i < 2 + 4 * n; i++) x ^= stim[i];
      exp_done = (stim[2 + 4 * n] == x);
    end
    for (int i = 0; i < stim.size(); i++) begin
      if (i == abort_at) break;
      wend = ok_len && (i >= 2) && (i < 2 + 4 * n) && (((i - 2) % 4) == 3);
      w = (i >= 5) ? {stim[i-3], stim[i-2], stim[i-1], stim[i]} : 32'h0;
      send_byte(stim[i], gaps, wend, (i - 2) / 4, w);
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (abort_at >= 0) return;
    if (!ok_len) begin
      check("err_after_hdr", 64'(err), 64'd1);
      check("ready_after_hdr_err", 64'(in_ready), 64'd0);
    end
    repeat (3) @(negedge clk);
    check("final_done", 64'(done), 64'(exp_done));
    check("final_err", 64'(err), 64'(!exp_done));
    check("final_cpu_reset", 64'(cpu_reset), 64'(!exp_done));
    check("final_in_ready", 64'(in_ready), 64'd0);
    check("writes_outstanding", 64'(expq.size()), 64'd0);
  endtask

  task automatic build_words(input int n, input logic [31:0] base, input bit rnd,
                             input logic [7:0] chk_xor);
    logic [31:0] w;
    logic [7:0]  x;
    stim.delete();
    stim.push_back(8'(n >> 8));
    stim.push_back(8'(n));
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      w = rnd ? $urandom : base + 32'(k);
      for (int j = 3; j >= 0; j--) begin
        stim.push_back(w[j*8 +: 8]);
        x ^= w[j*8 +: 8];
      end
    end
    stim.push_back(x ^ chk_xor);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Single word DEADBEEF, good checksum.
    stim = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    run_load(1'b0, -1);
    // Bytes offered after completion are refused.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (4) @(negedge clk);
    check("done_refuses_bytes", 64'(in_ready), 64'd0);
    check("done_sticky", 64'(done), 64'd1);
    in_valid = 1'b0;

    // Three sequential words, back-to-back, good and bad checksum.
    do_reset();
    build_words(3, 32'h1, 1'b0, 8'h00);
    run_load(1'b0, -1);
    do_reset();
    build_words(3, 32'h1, 1'b0, 8'hFF);
    run_load(1'b0, -1);

    // Oversized count: rejected right after the header, no writes.
    do_reset();
    stim = '{8'h04, 8'h01};
    run_load(1'b0, -1);

    // Empty image: good and bad checksum.
    do_reset();
    stim = '{8'h00, 8'h00, 8'h00};
    run_load(1'b0, -1);
    do_reset();
    stim = '{8'h00, 8'h00, 8'h01};
    run_load(1'b0, -1);

    // Reset in the middle of the second word, then a full reload with gaps.
    do_reset();
    build_words(2, 32'h0, 1'b1, 8'h00);
    run_load(1'b1, 8);
    check("mid_abort_writes", 64'(expq.size()), 64'd0);
    do_reset();
    build_words(2, 32'h0, 1'b1, 8'h00);
    run_load(1'b1, -1);

    // Random images with random gaps and occasional corrupted checksum.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      build_words($urandom_range(1, 6), 32'h0, 1'b1,
                  ($urandom_range(0, 3) == 0) ? 8'h5A : 8'h00);
      run_load(1'b1, -1);
    end

    // Largest image: fills every address exactly once.
    do_reset();
    build_words(1 << AW, 32'h0, 1'b1, 8'h00);
    run_load(1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
